// File: rtl/hilo_muldiv.sv
// HI/LO register unit: single-cycle MULT/MULTU, 33-cycle restoring DIV/DIVU, MTHI/MTLO.
// Define HILO_FWD_EN to forward the value being written this cycle onto hi_out/lo_out.
//   state | meaning
//   IDLE  | accept mult/div/mthi/mtlo
//   RUN   | divide iterating, one quotient bit per cycle
module hilo_muldiv #(
   parameter int DIV_ITERS = 32
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] a,
   input  logic [31:0] b,
   input  logic [2:0]  md_op,
   input  logic [1:0]  hilowrite,
   input  logic        flush,
   output logic        stall,
   output logic        div_done,
   output logic [31:0] hi_out,
   output logic [31:0] lo_out
);

   localparam int CW = (DIV_ITERS > 1) ? $clog2(DIV_ITERS) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(DIV_ITERS - 1);

   typedef enum logic {IDLE, RUN} state_t;

   state_t         state, state_d;
   logic [CW-1:0]  cnt, cnt_d;
   logic [31:0]    dvd, dvd_d;
   logic [31:0]    dvs, dvs_d;
   logic [31:0]    rem, rem_d;
   logic           neg_q, neg_q_d;
   logic           neg_r, neg_r_d;
   logic [31:0]    hi, hi_d;
   logic [31:0]    lo, lo_d;

   logic [63:0]    prod_s, prod_u;
   logic [32:0]    rem_sh;
   logic [31:0]    diff;
   logic           qbit;
   logic [31:0]    step_rem, step_quo;
   logic [31:0]    q_fin, r_fin;
   logic           sgn_a, sgn_b;

   assign prod_s = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
   assign prod_u = {32'b0, a} * {32'b0, b};

   // dvd holds the dividend and shifts quotient bits in from the bottom
   always_comb begin
      rem_sh   = {rem, dvd[31]};
      qbit     = (rem_sh >= {1'b0, dvs});
      diff     = rem_sh[31:0] - dvs;
      step_rem = qbit ? diff : rem_sh[31:0];
      step_quo = {dvd[30:0], qbit};
      q_fin    = neg_q ? (32'd0 - step_quo) : step_quo;
      r_fin    = neg_r ? (32'd0 - step_rem) : step_rem;
   end

   assign sgn_a = ~md_op[0] & a[31];
   assign sgn_b = ~md_op[0] & b[31];

   always_comb begin
      state_d  = state;
      cnt_d    = cnt;
      dvd_d    = dvd;
      dvs_d    = dvs;
      rem_d    = rem;
      neg_q_d  = neg_q;
      neg_r_d  = neg_r;
      hi_d     = hi;
      lo_d     = lo;
      stall    = 1'b0;
      div_done = 1'b0;
      case (state)
         IDLE: begin
            if (!flush) begin
               if (md_op[2] && !md_op[1]) begin
                  {hi_d, lo_d} = md_op[0] ? prod_u : prod_s;
               end else if (md_op[2] && md_op[1]) begin
                  stall   = 1'b1;
                  dvd_d   = sgn_a ? (32'd0 - a) : a;
                  dvs_d   = sgn_b ? (32'd0 - b) : b;
                  neg_q_d = sgn_a ^ sgn_b;
                  neg_r_d = sgn_a;
                  rem_d   = '0;
                  cnt_d   = '0;
                  state_d = RUN;
               end else if (hilowrite == 2'b10) begin
                  hi_d = a;
               end else if (hilowrite == 2'b01) begin
                  lo_d = a;
               end
            end
         end
         RUN: begin
            if (flush) begin
               state_d = IDLE;
            end else begin
               dvd_d = step_quo;
               rem_d = step_rem;
               if (cnt == CNT_LAST) begin
                  div_done = 1'b1;
                  hi_d     = r_fin;
                  lo_d     = q_fin;
                  cnt_d    = '0;
                  state_d  = IDLE;
               end else begin
                  stall = 1'b1;
                  cnt_d = cnt + CW'(1);
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         cnt   <= '0;
         dvd   <= '0;
         dvs   <= '0;
         rem   <= '0;
         neg_q <= 1'b0;
         neg_r <= 1'b0;
         hi    <= '0;
         lo    <= '0;
      end else begin
         state <= state_d;
         cnt   <= cnt_d;
         dvd   <= dvd_d;
         dvs   <= dvs_d;
         rem   <= rem_d;
         neg_q <= neg_q_d;
         neg_r <= neg_r_d;
         hi    <= hi_d;
         lo    <= lo_d;
      end
   end

`ifdef HILO_FWD_EN
   assign hi_out = hi_d;
   assign lo_out = lo_d;
`else
   assign hi_out = hi;
   assign lo_out = lo;
`endif

endmodule

// File: doc/hilo_muldiv.md
Name: hilo_muldiv

Overview:
- Execute-stage HI/LO unit sitting directly downstream of the main decoder.
- Consumes the decoder's 2-bit hilowrite control (MTHI/MTLO) plus a multiply/divide opcode from the ALU decoder.
- Owns the architectural HI/LO registers: single-cycle MULT/MULTU and a 32-iteration restoring DIV/DIVU.
- Drives a stall to the pipeline control while a divide is in flight; hi_out/lo_out feed the MFHI/MFLO path.

Parameters:
- DIV_ITERS, 32, number of divide iteration cycles; fixed at 32 for 32-bit operands, present for bench shortening only.

Ports:
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  synchronous active-high reset
- a  in  32  operand rs (dividend / multiplicand / MTHI-MTLO source)
- b  in  32  operand rt (divisor / multiplier)
- md_op  in  3  000 none, 100 MULT, 101 MULTU, 110 DIV, 111 DIVU; other codes = none
- hilowrite  in  2  from decoder: 10 write HI<=a, 01 write LO<=a, 00 none; 11 treated as none
- flush  in  1  cancel in-flight divide / suppress current op
- stall  out  1  hold EX stage
- div_done  out  1  one-cycle pulse on the divide commit cycle
- hi_out  out  32  HI value
- lo_out  out  32  LO value

Behaviour:
- Reset (synchronous, active-high): HI=0, LO=0, state=IDLE, stall=0, div_done=0, iteration counter=0, operand latches=0. Reset mid-divide aborts it with no HI/LO write.
- States: IDLE, RUN.
- IDLE, md_op MULT/MULTU, flush=0:
  - {HI,LO} <= 64-bit product at the clock edge; MULT signed, MULTU unsigned.
  - stall=0 throughout; zero added latency.
- IDLE, md_op DIV/DIVU, flush=0 (accept cycle, cycle 0):
  - stall=1 combinationally.
  - Latch |a|, |b| (DIVU: raw values) plus sign flags.
  - Clear remainder; counter=0; go to RUN.
- RUN:
  - Cycles 1..32: one restoring step per cycle, MSB-first quotient bit.
  - stall=1 in cycles 1..31; stall=0 and div_done=1 in cycle 32 (counter==DIV_ITERS-1).
  - At the end of cycle 32: HI <= remainder, LO <= quotient; state -> IDLE.
  - md_op and hilowrite are ignored while in RUN. The stalled DIV instruction stays on md_op but must not restart; it advances after cycle 32.
  - Total: 33 cycles accept-to-commit, 32 stall cycles.
- Signed fix-up on commit (DIV only):
  - Quotient negated if operand signs differ.
  - Remainder takes the sign of the dividend.
- Divide by zero: no trap; still 33 cycles.
  - DIVU: LO=0xFFFFFFFF, HI=a.
  - DIV: magnitude result, then the same sign fix-up.
- Overflow: DIV 0x80000000 / 0xFFFFFFFF gives LO=0x80000000, HI=0.
- hilowrite (IDLE, md_op none, flush=0):
  - 10: HI<=a.
  - 01: LO<=a.
  - Other register unchanged; stall=0.
- Simultaneous md_op and hilowrite in IDLE: md_op wins, hilowrite dropped (the decoder never issues both).
- flush:
  - In RUN: state -> IDLE at the edge, no HI/LO write, div_done=0, stall=0 combinationally in that cycle.
  - In IDLE: current md_op/hilowrite suppressed, no state change.
  - Priority: rst > flush > completion.
- Outputs hi_out/lo_out are the register values (1-cycle write-to-read latency) unless HILO_FWD_EN.

Optional Feature:
- Macro: HILO_FWD_EN
- Defined: hi_out/lo_out combinationally present the value being committed this cycle (MTHI/MTLO source a, MULT product halves, DIV commit result in cycle 32). An MFHI in the same cycle as the write sees the new value; non-written halves pass the register value.
- Undefined: hi_out/lo_out are pure register outputs; the hazard unit must cover the 1-cycle gap.

Test Plan:
- Reset then MTHI a=0x12345678, next cycle MTLO a=0x9ABCDEF0 -> HI=0x12345678, LO=0x9ABCDEF0; stall never high.
- MULT a=0xFFFFFFFE (-2), b=3 -> {HI,LO}=0xFFFFFFFF_FFFFFFFA one edge later; MULTU same operands -> HI=0x00000002, LO=0xFFFFFFFA.
- DIV a=-7 (0xFFFFFFF9), b=2 with md_op held -> stall high 32 cycles, div_done in cycle 32, LO=0xFFFFFFFD, HI=0xFFFFFFFF; DIVU 100/7 -> LO=14, HI=2.
- DIV 0x80000000 / 0xFFFFFFFF -> LO=0x80000000, HI=0; DIVU 5/0 -> LO=0xFFFFFFFF, HI=5, 33-cycle latency.
- Start DIVU 100/7, assert flush at cycle 10 -> stall=0 that cycle, state IDLE, HI/LO keep pre-divide values, no div_done.
- Start DIV, assert rst at cycle 5 -> HI=LO=0, stall=0 next cycle; with HILO_FWD_EN, MTHI a=0xCAFEF00D -> hi_out=0xCAFEF00D in the same cycle.
